// File: rtl/uart_cmd_framer_if.sv
// Bundles the receiver, command-consumer and transmitter handshakes of the
// UART command framer. The framer itself uses the slave modport; whatever
// surrounds it (UART core, command decoder, bench) uses the master modport.
interface uart_cmd_framer_if #(
  parameter int CMD_BYTES  = 2,
  parameter int RESP_BYTES = 1
);
  // receive byte stream
  logic                    rx_rdy;
  logic [7:0]              rx_data;
  logic                    clr_rx_rdy;
  // assembled command towards the consumer
  logic [8*CMD_BYTES-1:0]  cmd;
  logic                    cmd_rdy;
  logic                    clr_cmd_rdy;
  logic                    overrun;
  logic                    frame_err;
  // response towards the transmitter
  logic                    send_resp;
  logic [8*RESP_BYTES-1:0] resp;
  logic                    trmt;
  logic [7:0]              tx_data;
  logic                    tx_done;
  logic                    resp_sent;
  logic                    tx_busy;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, overrun, frame_err,
           trmt, tx_data, resp_sent, tx_busy
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, overrun, frame_err,
           trmt, tx_data, resp_sent, tx_busy
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// UART command framer: assembles CMD_BYTES received bytes into a command word
// (first byte in the MSBs) with an inter-byte timeout, and serialises a
// RESP_BYTES response word MSB-first through a byte-wide transmitter.
// Receive and transmit sides are fully independent.
module uart_cmd_framer #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_framer_if.slave   bus
);

  localparam int CW = 8*CMD_BYTES;
  localparam int RW = 8*RESP_BYTES;
  localparam int NW = $clog2(CMD_BYTES+1);
  localparam int LW = $clog2(RESP_BYTES+1);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC+1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYC > 0);

  // index of the byte that completes a frame
  localparam logic [NW-1:0] LAST_IDX = NW'(CMD_BYTES-1);
  // timer value at which one more idle cycle expires the frame
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC-1 : 0);
  localparam logic [LW-1:0] RESP_REM = LW'(RESP_BYTES-1);

  typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

  rx_state_t      r_rx_st;
  logic [NW-1:0]  r_cnt;
  logic [TW-1:0]  r_timer;
  logic [CW-1:0]  r_asm;
  logic [CW-1:0]  r_cmd;
  logic           r_cmd_rdy;
  logic           r_overrun;
  logic           r_frame_err;

  tx_state_t      r_tx_st;
  logic [RW-1:0]  r_resp;
  logic [LW-1:0]  r_left;
  logic [7:0]     r_tx_data;
  logic           r_trmt;
  logic           r_resp_sent;
  logic           r_tx_busy;

  logic           w_accept;
  logic           w_complete;
  logic           w_timeout;
  logic [CW-1:0]  w_asm_next;

  // A waiting byte is always taken in the cycle it is offered, so the
  // consume strobe is just the ready flag, held low while in reset.
  assign w_accept   = bus.rx_rdy;
  assign w_complete = w_accept && (r_cnt == LAST_IDX);
  assign w_asm_next = CW'({r_asm, bus.rx_data});
  // an arriving byte beats the timeout in the same cycle
  assign w_timeout  = TMO_EN && (r_rx_st == RX_COLLECT) && !bus.rx_rdy &&
                      (r_timer == TMO_LAST);

  assign bus.clr_rx_rdy = w_accept & rst_n;
  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = r_frame_err;
  assign bus.trmt       = r_trmt;
  assign bus.tx_data    = r_tx_data;
  assign bus.resp_sent  = r_resp_sent;
  assign bus.tx_busy    = r_tx_busy;

  // Receive FSM: shift bytes in, publish on completion, drop partial on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st     <= RX_IDLE;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_asm       <= '0;
      r_cmd       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_accept) begin
        r_timer <= '0;
        if (w_complete) begin
          r_cmd   <= w_asm_next;
          r_asm   <= '0;
          r_cnt   <= '0;
          r_rx_st <= RX_IDLE;
        end else begin
          r_asm   <= w_asm_next;
          r_cnt   <= r_cnt + 1'b1;
          r_rx_st <= RX_COLLECT;
        end
      end else if (r_rx_st == RX_COLLECT) begin
        if (w_timeout) begin
          r_frame_err <= 1'b1;
          r_asm       <= '0;
          r_cnt       <= '0;
          r_timer     <= '0;
          r_rx_st     <= RX_IDLE;
        end else if (TMO_EN) begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  // Command status: completion beats acknowledge; overrun flags a lost command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_rdy <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_complete)            r_cmd_rdy <= 1'b1;
      else if (bus.clr_cmd_rdy)  r_cmd_rdy <= 1'b0;

      if (w_complete && r_cmd_rdy && !bus.clr_cmd_rdy) r_overrun <= 1'b1;
      else if (bus.clr_cmd_rdy)                        r_overrun <= 1'b0;
    end
  end

  // Transmit FSM: trmt is high exactly while in SEND, so the next byte
  // launches the cycle right after tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st     <= TX_IDLE;
      r_resp      <= '0;
      r_left      <= '0;
      r_tx_data   <= 8'h00;
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
      r_tx_busy   <= 1'b0;
    end else begin
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
      case (r_tx_st)
        TX_IDLE: begin
          if (bus.send_resp) begin
            r_tx_data <= bus.resp[RW-1 -: 8];
            r_resp    <= bus.resp << 8;
            r_left    <= RESP_REM;
            r_trmt    <= 1'b1;
            r_tx_busy <= 1'b1;
            r_tx_st   <= TX_SEND;
          end
        end
        TX_SEND: r_tx_st <= TX_WAIT;
        TX_WAIT: begin
          if (bus.tx_done) begin
            if (r_left != '0) begin
              r_tx_data <= r_resp[RW-1 -: 8];
              r_resp    <= r_resp << 8;
              r_left    <= r_left - 1'b1;
              r_trmt    <= 1'b1;
              r_tx_st   <= TX_SEND;
            end else begin
              r_resp_sent <= 1'b1;
              r_tx_busy   <= 1'b0;
              r_tx_st     <= TX_IDLE;
            end
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_framer.md
UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

Interface
REQ-001 SHALL provide parameter CMD_BYTES, default 2, meaning bytes per received command (legal 1..8).
REQ-002 SHALL provide parameter RESP_BYTES, default 1, meaning bytes per transmitted response (legal 1..8).
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 65535, meaning inter-byte timeout in clk cycles; 0 disables timeout.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_rdy  input  1  UART receiver holds a byte.
REQ-007 rx_data  input  8  received byte, valid while rx_rdy=1.
REQ-008 clr_rx_rdy  output  1  one-cycle pulse consuming the receiver byte.
REQ-009 cmd  output  8*CMD_BYTES  last completed command, first byte received in MSBs.
REQ-010 cmd_rdy  output  1  completed command available.
REQ-011 clr_cmd_rdy  input  1  consumer acknowledges cmd.
REQ-012 overrun  output  1  sticky, command completed while previous one unacknowledged.
REQ-013 frame_err  output  1  one-cycle pulse, partial frame discarded on timeout.
REQ-014 send_resp  input  1  start response transmission.
REQ-015 resp  input  8*RESP_BYTES  response word, sampled on accepted send_resp.
REQ-016 trmt  output  1  one-cycle pulse to UART transmitter.
REQ-017 tx_data  output  8  byte for transmitter, stable from trmt until tx_done.
REQ-018 tx_done  input  1  transmitter finished current byte.
REQ-019 resp_sent  output  1  one-cycle pulse after last response byte done.
REQ-020 tx_busy  output  1  response in progress.

Function
REQ-021 Receive FSM SHALL have states IDLE and COLLECT plus a byte counter of ceil(log2(CMD_BYTES+1)) bits.
REQ-022 On rx_rdy=1 in either state: shift rx_data into assembly register, assert clr_rx_rdy that same cycle, increment counter, clear inter-byte timer.
REQ-023 When the accepted byte is byte CMD_BYTES: copy assembly register (with new byte) to cmd next edge, set cmd_rdy, reset counter, go IDLE; CMD_BYTES=1 completes on every byte.
REQ-024 Otherwise IDLE->COLLECT on first byte; COLLECT holds until completion or timeout.
REQ-025 cmd SHALL change only on frame completion; partial frames never visible on cmd.
REQ-026 In COLLECT without rx_rdy, timer increments; on reaching TIMEOUT_CYC: pulse frame_err, discard bytes, counter=0, go IDLE.
REQ-027 rx_rdy in the timeout cycle SHALL win: byte accepted, no frame_err.
REQ-028 cmd_rdy: set on completion, cleared by clr_cmd_rdy; simultaneous set and clear -> cmd_rdy=1.
REQ-029 Completion while cmd_rdy=1 and clr_cmd_rdy=0: overwrite cmd, set overrun; overrun cleared only by clr_cmd_rdy (set wins if simultaneous).
REQ-030 Transmit FSM SHALL have states IDLE, SEND, WAIT; send_resp in IDLE latches resp, enters SEND.
REQ-031 SEND: pulse trmt one cycle with tx_data = most significant unsent byte, go WAIT.
REQ-032 WAIT on tx_done: if bytes remain go SEND (next trmt exactly 1 cycle after tx_done), else pulse resp_sent, go IDLE.
REQ-033 send_resp while tx_busy=1 SHALL be ignored; tx_busy=1 in SEND and WAIT.
REQ-034 Receive and transmit paths SHALL operate independently and concurrently.

Reset
REQ-035 rst_n low SHALL immediately force: both FSMs IDLE, counters/timer 0, cmd=0, cmd_rdy=0, overrun=0, frame_err=0, clr_rx_rdy=0, trmt=0, tx_data=0x00, resp_sent=0, tx_busy=0.
REQ-036 Reset mid-frame or mid-response SHALL discard all partial state; no pulses after release until new stimulus.

Verification
REQ-037 CMD_BYTES=2: bytes 0xA5 then 0x3C -> one clr_rx_rdy per byte, cmd=0xA53C, cmd_rdy=1 the cycle after second byte, overrun=0.
REQ-038 CMD_BYTES=3, TIMEOUT_CYC=100: send 0x11, wait 100 idle cycles -> frame_err one pulse, cmd unchanged; then 0x01,0x02,0x03 -> cmd=0x010203.
REQ-039 Two 2-byte frames 0x1234, 0x5678 without clr_cmd_rdy -> cmd=0x5678, overrun=1; clr_cmd_rdy -> cmd_rdy=0, overrun=0.
REQ-040 RESP_BYTES=3, resp=0xC0FFEE -> trmt pulses with tx_data 0xC0,0xFF,0xEE, each after prior tx_done; single resp_sent after third tx_done; mid-response send_resp ignored.
REQ-041 Completion coincident with clr_cmd_rdy -> cmd_rdy=1, overrun=0; rx_rdy in timeout cycle -> no frame_err.
REQ-042 rst_n asserted after first of two bytes and during WAIT -> all outputs at reset values; next full frame assembles correctly.
